// File: rtl/pr_pkg.sv
// Shared opcode and state encodings plus default geometry for the
// pending-request data queue.
package pr_pkg;

    localparam int DEF_ADDR_BITS      = 64;
    localparam int DEF_LOG_QUEUE_SIZE = 6;
    localparam int DEF_DATA_WIDTH     = 64;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH_REQ = 3'd1,
        OP_LOOKUP   = 3'd2,
        OP_POP      = 3'd3,
        OP_FILL     = 3'd4
    } pr_op_e;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_CLEANUP = 1'b1
    } pr_state_e;

endpackage

// File: rtl/pr_data_queue_if.sv
// Request/response bundle of the pending-request queue; the master side
// issues opcodes and returned beats, the slave side is the queue itself.
interface pr_data_queue_if
    import pr_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int LOG_QUEUE_SIZE = DEF_LOG_QUEUE_SIZE,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
);
    logic                      pr_flush;
    logic [2:0]                pr_opCode;
    logic [ADDR_BITS-1:0]      pr_addr_in;
    logic [DATA_WIDTH-1:0]     pr_data_in;
    logic                      pr_last_in;

    logic                      pr_addrHit;
    logic                      pr_hasOutstanding;
    logic [LOG_QUEUE_SIZE:0]   pr_reqCnt;
    logic                      pr_almostFull;
    logic                      pr_isCleanup;
    logic                      pr_r_valid;
    logic [DATA_WIDTH-1:0]     pr_r_data;
    logic                      pr_r_last;
    logic                      pr_error;

    modport master (
        output pr_flush, pr_opCode, pr_addr_in, pr_data_in, pr_last_in,
        input  pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull,
        input  pr_isCleanup, pr_r_valid, pr_r_data, pr_r_last, pr_error
    );

    modport slave (
        input  pr_flush, pr_opCode, pr_addr_in, pr_data_in, pr_last_in,
        output pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull,
        output pr_isCleanup, pr_r_valid, pr_r_data, pr_r_last, pr_error
    );

endinterface

// File: rtl/pr_queue_mem.sv
// Entry storage: addr/data/last arrays plus per-entry ready flags, with a
// request write port, a fill write port and an asynchronous head read.
module pr_queue_mem
    import pr_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int LOG_QUEUE_SIZE = DEF_LOG_QUEUE_SIZE,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      clear,
    input  logic                      push_en,
    input  logic [LOG_QUEUE_SIZE-1:0] push_idx,
    input  logic [ADDR_BITS-1:0]      push_addr,
    input  logic                      fill_en,
    input  logic [LOG_QUEUE_SIZE-1:0] fill_idx,
    input  logic [DATA_WIDTH-1:0]     fill_data,
    input  logic                      fill_last,
    input  logic [LOG_QUEUE_SIZE-1:0] rd_idx,
    output logic [ADDR_BITS-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      rd_ready
);
    localparam int QSIZE = 1 << LOG_QUEUE_SIZE;
    typedef logic [LOG_QUEUE_SIZE-1:0] ptr_t;

    logic [ADDR_BITS-1:0]  addr_mem [QSIZE];
    logic [DATA_WIDTH-1:0] data_mem [QSIZE];
    logic                  last_mem [QSIZE];
    logic                  ready_reg [QSIZE];

    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_mem[push_idx] <= push_addr;
        end
        if (fill_en) begin
            data_mem[fill_idx] <= fill_data;
            last_mem[fill_idx] <= fill_last;
        end
    end

    // Ready flags need reset and bulk clear, so they live in flops, not RAM.
    generate
        for (genvar gi = 0; gi < QSIZE; gi++) begin : g_ready
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    ready_reg[gi] <= 1'b0;
                end else if (clear) begin
                    ready_reg[gi] <= 1'b0;
                end else if (fill_en && fill_idx == ptr_t'(gi)) begin
                    ready_reg[gi] <= 1'b1;
                end else if (push_en && push_idx == ptr_t'(gi)) begin
                    ready_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign rd_addr  = addr_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
    assign rd_last  = last_mem[rd_idx];
    assign rd_ready = ready_reg[rd_idx];

endmodule

// File: rtl/pr_data_queue.sv
// Circular queue of outstanding read requests: pushes reserve entries, fills
// complete them in order, pops retire the head; a flush discards late fills.
module pr_data_queue
    import pr_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int LOG_QUEUE_SIZE = DEF_LOG_QUEUE_SIZE,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,
    pr_data_queue_if.slave   bus
);
    typedef logic [LOG_QUEUE_SIZE-1:0] ptr_t;
    typedef logic [LOG_QUEUE_SIZE:0]   cnt_t;

    localparam int   QSIZE_INT = 1 << LOG_QUEUE_SIZE;
    localparam cnt_t QSIZE     = cnt_t'(QSIZE_INT);

    ptr_t      head_reg, head_next;
    ptr_t      tail_reg, tail_next;
    ptr_t      fill_reg, fill_next;
    cnt_t      count_reg, count_next;
    cnt_t      discard_reg, discard_next;
    pr_state_e state_reg, state_next;
    logic      error_reg, error_next;

    logic                  push_en, fill_en, clear;
    logic [ADDR_BITS-1:0]  head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  head_ready;
    logic                  cleanup;
    cnt_t                  ready_cnt;
    cnt_t                  pending_cnt;

    pr_queue_mem #(
        .ADDR_BITS      (ADDR_BITS),
        .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (clear),
        .push_en   (push_en),
        .push_idx  (tail_reg),
        .push_addr (bus.pr_addr_in),
        .fill_en   (fill_en),
        .fill_idx  (fill_reg),
        .fill_data (bus.pr_data_in),
        .fill_last (bus.pr_last_in),
        .rd_idx    (head_reg),
        .rd_addr   (head_addr),
        .rd_data   (head_data),
        .rd_last   (head_last),
        .rd_ready  (head_ready)
    );

    assign cleanup = (state_reg == ST_CLEANUP);

    // Filled entries sit between head and fill; fill==head is ambiguous when
    // occupied, and the head ready flag tells "all filled" from "none filled".
    always_comb begin
        ready_cnt = {1'b0, ptr_t'(fill_reg - head_reg)};
        if (count_reg != '0 && fill_reg == head_reg && head_ready) begin
            ready_cnt = QSIZE;
        end
        pending_cnt = count_reg - ready_cnt;
    end

    always_comb begin
        head_next    = head_reg;
        tail_next    = tail_reg;
        fill_next    = fill_reg;
        count_next   = count_reg;
        discard_next = discard_reg;
        state_next   = state_reg;
        error_next   = 1'b0;
        push_en      = 1'b0;
        fill_en      = 1'b0;
        clear        = 1'b0;

        if (bus.pr_flush) begin
            head_next  = '0;
            tail_next  = '0;
            fill_next  = '0;
            count_next = '0;
            clear      = 1'b1;
            if (!cleanup) begin
                discard_next = pending_cnt;
                if (pending_cnt != '0) begin
                    state_next = ST_CLEANUP;
                end
            end
        end else begin
            case (bus.pr_opCode)
                OP_NOP, OP_LOOKUP: begin
                end
                OP_PUSH_REQ: begin
                    if (cleanup || count_reg == QSIZE) begin
                        error_next = 1'b1;
                    end else begin
                        push_en    = 1'b1;
                        tail_next  = tail_reg + ptr_t'(1);
                        count_next = count_reg + cnt_t'(1);
                    end
                end
                OP_POP: begin
                    if (cleanup || count_reg == '0 || !head_ready) begin
                        error_next = 1'b1;
                    end else begin
                        head_next  = head_reg + ptr_t'(1);
                        count_next = count_reg - cnt_t'(1);
                    end
                end
                OP_FILL: begin
                    if (cleanup) begin
                        // Late beat for a flushed request: count it off, store nothing.
                        discard_next = discard_reg - cnt_t'(1);
                        if (discard_reg == cnt_t'(1)) begin
                            state_next = ST_NORMAL;
                        end
                    end else if (pending_cnt == '0) begin
                        error_next = 1'b1;
                    end else begin
                        fill_en   = 1'b1;
                        fill_next = fill_reg + ptr_t'(1);
                    end
                end
                default: begin
                    error_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            fill_reg    <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
            state_reg   <= ST_NORMAL;
            error_reg   <= 1'b0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            fill_reg    <= fill_next;
            count_reg   <= count_next;
            discard_reg <= discard_next;
            state_reg   <= state_next;
            error_reg   <= error_next;
        end
    end

    assign bus.pr_addrHit        = (count_reg != '0) && (head_addr == bus.pr_addr_in);
    assign bus.pr_hasOutstanding = (fill_reg != tail_reg) || (count_reg == QSIZE && !head_ready);
    assign bus.pr_reqCnt         = count_reg;
    assign bus.pr_almostFull     = (count_reg >= (QSIZE - cnt_t'(1)));
    assign bus.pr_isCleanup      = cleanup;
    assign bus.pr_r_valid        = (count_reg != '0) && head_ready && !cleanup;
    assign bus.pr_r_data         = head_data;
    assign bus.pr_r_last         = head_last;
    assign bus.pr_error          = error_reg;

endmodule

// File: tb/tb_pr_data_queue.sv
// Directed bench for pr_data_queue: stimulus queues expected observations,
// a negedge monitor pops and compares them on their scheduled cycle.
module tb_pr_data_queue;
    import pr_pkg::*;

    localparam int F_CNT   = 0;
    localparam int F_OUT   = 1;
    localparam int F_VALID = 2;
    localparam int F_DATA  = 3;
    localparam int F_LAST  = 4;
    localparam int F_AFULL = 5;
    localparam int F_ERR   = 6;
    localparam int F_CLEAN = 7;
    localparam int F_HIT   = 8;

    typedef struct {
        int          cyc;
        int          fld;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    pr_data_queue_if bus ();

    pr_data_queue dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int   cyc = 0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] sample(input int f);
        case (f)
            F_CNT:   return 64'(bus.pr_reqCnt);
            F_OUT:   return 64'(bus.pr_hasOutstanding);
            F_VALID: return 64'(bus.pr_r_valid);
            F_DATA:  return bus.pr_r_data;
            F_LAST:  return 64'(bus.pr_r_last);
            F_AFULL: return 64'(bus.pr_almostFull);
            F_ERR:   return 64'(bus.pr_error);
            F_CLEAN: return 64'(bus.pr_isCleanup);
            F_HIT:   return 64'(bus.pr_addrHit);
            default: return '0;
        endcase
    endfunction

    function automatic void expect_at(input int c, input int f, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.fld  = f;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endfunction

    // Registered outputs after the op driven this cycle is clocked in.
    function automatic void st(input int f, input logic [63:0] v, input string nm);
        expect_at(cyc + 1, f, v, nm);
    endfunction

    // Combinational hit against the address driven this cycle.
    function automatic void hit(input logic v, input string nm);
        expect_at(cyc, F_HIT, 64'(v), nm);
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e     = sb.pop_front();
            act   = sample(e.fld);
            n_cmp = n_cmp + 1;
            if (e.cyc != cyc || act !== e.val) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                         e.name, act, cyc, e.val, e.cyc);
            end else begin
                $display("ok   %s = 0x%0h (cycle %0d)", e.name, act, cyc);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d,
                         input logic l, input logic f);
        @(posedge clk);
        #1;
        bus.pr_opCode  = op;
        bus.pr_addr_in = a;
        bus.pr_data_in = d;
        bus.pr_last_in = l;
        bus.pr_flush   = f;
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #1;
        resetN         = 1'b0;
        bus.pr_opCode  = OP_NOP;
        bus.pr_flush   = 1'b0;
        expect_at(cyc, F_CNT,   64'd0, {tag, " reqCnt"});
        expect_at(cyc, F_OUT,   64'd0, {tag, " hasOutstanding"});
        expect_at(cyc, F_VALID, 64'd0, {tag, " r_valid"});
        expect_at(cyc, F_AFULL, 64'd0, {tag, " almostFull"});
        expect_at(cyc, F_ERR,   64'd0, {tag, " error"});
        expect_at(cyc, F_CLEAN, 64'd0, {tag, " isCleanup"});
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pr_flush   = 1'b0;
        bus.pr_opCode  = OP_NOP;
        bus.pr_addr_in = '0;
        bus.pr_data_in = '0;
        bus.pr_last_in = 1'b0;
        reset_pulse("reset");

        // Three requests, then lookup and first fill/pop
        drive(OP_PUSH_REQ, 64'hdeadbeef, 0, 0, 0);
        drive(OP_PUSH_REQ, 64'hdeadbf2f, 0, 0, 0);
        drive(OP_PUSH_REQ, 64'hdeadbf6f, 0, 0, 0);
        st(F_CNT, 3, "push3 reqCnt"); st(F_OUT, 1, "push3 outstanding"); st(F_VALID, 0, "push3 r_valid");
        drive(OP_LOOKUP, 64'hdeadbeef, 0, 0, 0); hit(1, "lookup head hit");
        drive(OP_LOOKUP, 64'hdeadbf2f, 0, 0, 0); hit(0, "lookup non-head miss");
        st(F_CNT, 3, "lookup reqCnt");
        drive(OP_FILL, 0, 64'h11, 1, 0);
        st(F_VALID, 1, "fill1 r_valid"); st(F_DATA, 64'h11, "fill1 r_data");
        st(F_LAST, 1, "fill1 r_last"); st(F_OUT, 1, "fill1 outstanding");
        drive(OP_POP, 0, 0, 0, 0);
        st(F_CNT, 2, "pop1 reqCnt"); st(F_ERR, 0, "pop1 error");
        drive(OP_LOOKUP, 64'hdeadbf2f, 0, 0, 0); hit(1, "lookup new head hit");
        st(F_VALID, 0, "unfilled head r_valid");

        // Illegal operations
        drive(OP_POP, 0, 0, 0, 0);
        st(F_ERR, 1, "pop unready error"); st(F_CNT, 2, "pop unready reqCnt");
        drive(OP_NOP, 0, 0, 0, 0); st(F_ERR, 0, "error one-cycle");
        drive(OP_FILL, 0, 64'h22, 0, 0);
        st(F_VALID, 1, "fill2 r_valid"); st(F_DATA, 64'h22, "fill2 r_data"); st(F_LAST, 0, "fill2 r_last");
        drive(OP_FILL, 0, 64'h33, 1, 0); st(F_OUT, 0, "fill3 outstanding");
        drive(OP_FILL, 0, 64'h44, 0, 0);
        st(F_ERR, 1, "fill none pending error"); st(F_CNT, 2, "fill none pending reqCnt");
        st(F_DATA, 64'h22, "fill none pending head data");
        drive(3'd6, 0, 0, 0, 0);
        st(F_ERR, 1, "opcode6 error"); st(F_CNT, 2, "opcode6 reqCnt");
        drive(OP_NOP, 0, 0, 0, 0); st(F_ERR, 0, "opcode6 error cleared");
        drive(OP_POP, 0, 0, 0, 0);
        st(F_DATA, 64'h33, "pop2 r_data"); st(F_LAST, 1, "pop2 r_last"); st(F_CNT, 1, "pop2 reqCnt");
        drive(OP_POP, 0, 0, 0, 0);
        st(F_CNT, 0, "pop3 reqCnt"); st(F_VALID, 0, "pop3 r_valid");
        drive(OP_POP, 0, 0, 0, 0);
        st(F_ERR, 1, "pop empty error"); st(F_CNT, 0, "pop empty reqCnt");

        // Fill the queue completely, overflow, then drain with wrap
        for (int i = 0; i < 63; i++) begin
            drive(OP_PUSH_REQ, 64'h1000 + 64'(i), 0, 0, 0);
            if (i == 61) begin
                st(F_AFULL, 0, "62 entries almostFull"); st(F_CNT, 62, "62 entries reqCnt");
            end
        end
        st(F_AFULL, 1, "63 entries almostFull"); st(F_CNT, 63, "63 entries reqCnt");
        drive(OP_PUSH_REQ, 64'h1000 + 64'd63, 0, 0, 0);
        st(F_CNT, 64, "full reqCnt"); st(F_OUT, 1, "full unfilled outstanding");
        drive(OP_PUSH_REQ, 64'h2000, 0, 0, 0);
        st(F_ERR, 1, "overflow error"); st(F_CNT, 64, "overflow reqCnt");
        drive(OP_LOOKUP, 64'h1000, 0, 0, 0); hit(1, "full head hit");
        for (int i = 0; i < 64; i++) begin
            drive(OP_FILL, 0, 64'h500 + 64'(i), 1'(i), 0);
        end
        st(F_OUT, 0, "full filled outstanding"); st(F_VALID, 1, "full filled r_valid");
        st(F_DATA, 64'h500, "full filled head data");
        for (int i = 0; i < 64; i++) begin
            drive(OP_POP, 0, 0, 0, 0);
            if (i < 63 && (i % 8) == 0) begin
                st(F_DATA, 64'h500 + 64'(i + 1), $sformatf("drain pop%0d r_data", i));
            end
        end
        st(F_CNT, 0, "drained reqCnt"); st(F_AFULL, 0, "drained almostFull"); st(F_VALID, 0, "drained r_valid");
        drive(OP_PUSH_REQ, 64'habc, 0, 0, 0);
        drive(OP_LOOKUP, 64'habc, 0, 0, 0); hit(1, "wrapped head hit");
        st(F_CNT, 1, "wrapped reqCnt"); st(F_OUT, 1, "wrapped outstanding");

        // Flush with two pending and one ready entry
        drive(OP_PUSH_REQ, 64'hb1, 0, 0, 0);
        drive(OP_PUSH_REQ, 64'hb2, 0, 0, 0);
        drive(OP_FILL, 0, 64'h55, 1, 0); st(F_CNT, 3, "preflush reqCnt");
        drive(OP_PUSH_REQ, 64'hccc, 0, 0, 1);
        st(F_CNT, 0, "flush reqCnt"); st(F_CLEAN, 1, "flush isCleanup");
        st(F_VALID, 0, "flush r_valid"); st(F_ERR, 0, "flush error"); st(F_OUT, 0, "flush outstanding");
        drive(OP_POP, 0, 0, 0, 0);
        st(F_ERR, 1, "cleanup pop error"); st(F_CLEAN, 1, "cleanup pop isCleanup");
        drive(OP_PUSH_REQ, 64'hddd, 0, 0, 0);
        st(F_ERR, 1, "cleanup push error"); st(F_CNT, 0, "cleanup push reqCnt");
        drive(OP_NOP, 0, 0, 0, 1); st(F_CLEAN, 1, "reflush isCleanup");
        drive(OP_FILL, 0, 64'h77, 0, 0);
        st(F_CLEAN, 1, "discard1 isCleanup"); st(F_ERR, 0, "discard1 error");
        drive(OP_FILL, 0, 64'h78, 1, 0);
        st(F_CLEAN, 0, "discard2 isCleanup"); st(F_ERR, 0, "discard2 error");
        drive(OP_FILL, 0, 64'h79, 0, 0); st(F_ERR, 1, "post cleanup fill error");

        // Flush with nothing pending never enters cleanup
        drive(OP_PUSH_REQ, 64'he1, 0, 0, 0);
        drive(OP_FILL, 0, 64'h66, 0, 0);
        drive(OP_NOP, 0, 0, 0, 1);
        st(F_CLEAN, 0, "clean flush isCleanup"); st(F_CNT, 0, "clean flush reqCnt");
        drive(OP_NOP, 0, 0, 0, 0); st(F_CLEAN, 0, "clean flush isCleanup later");

        // Reset during cleanup
        drive(OP_PUSH_REQ, 64'hf1, 0, 0, 0);
        drive(OP_PUSH_REQ, 64'hf2, 0, 0, 0);
        drive(OP_NOP, 0, 0, 0, 1); st(F_CLEAN, 1, "prereset isCleanup");
        drive(OP_NOP, 0, 0, 0, 0);
        reset_pulse("midcleanup reset");
        drive(OP_FILL, 0, 64'h88, 0, 0);
        st(F_ERR, 1, "post reset fill error"); st(F_CLEAN, 0, "post reset isCleanup");
        drive(OP_NOP, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d unchecked entries, expected 0", sb.size());
            n_bad = n_bad + sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
